// File: rtl/demux2way16_stream.sv
// demux2way16_stream: routes each accepted input word into one of two small
// output FIFOs (a when sel=0, b when sel=1) and counts accepts per port.
module demux2way16_stream #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [15:0]      cnt_a,
    output logic [15:0]      cnt_b
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW-1:0]    r_wptr_a, r_rptr_a, r_wptr_b, r_rptr_b;
    logic [WIDTH-1:0] r_mem_a [DEPTH];
    logic [WIDTH-1:0] r_mem_b [DEPTH];
    logic [15:0]      r_cnt_a, r_cnt_b;

    logic w_full_a, w_full_b, w_empty_a, w_empty_b;
    logic w_in_ready, w_push_a, w_push_b, w_pop_a, w_pop_b;

    // Occupancy flags, handshake qualification and output presentation.
    always_comb begin
        w_empty_a  = (r_wptr_a == r_rptr_a);
        w_empty_b  = (r_wptr_b == r_rptr_b);
        w_full_a   = (r_wptr_a[AW] != r_rptr_a[AW]) &&
                     (r_wptr_a[AW-1:0] == r_rptr_a[AW-1:0]);
        w_full_b   = (r_wptr_b[AW] != r_rptr_b[AW]) &&
                     (r_wptr_b[AW-1:0] == r_rptr_b[AW-1:0]);
        // Readiness looks only at the selected FIFO; sink ready never passes through.
        w_in_ready = !flush && (sel ? !w_full_b : !w_full_a);
        w_push_a   = in_valid && w_in_ready && !sel;
        w_push_b   = in_valid && w_in_ready && sel;
        w_pop_a    = !w_empty_a && a_ready && !flush;
        w_pop_b    = !w_empty_b && b_ready && !flush;

        in_ready   = w_in_ready;
        a_valid    = !w_empty_a;
        b_valid    = !w_empty_b;
        a_data     = r_mem_a[r_rptr_a[AW-1:0]];
        b_data     = r_mem_b[r_rptr_b[AW-1:0]];
        cnt_a      = r_cnt_a;
        cnt_b      = r_cnt_b;
    end

    // Storage writes; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push_a) begin
            r_mem_a[r_wptr_a[AW-1:0]] <= data_in;
        end
        if (w_push_b) begin
            r_mem_b[r_wptr_b[AW-1:0]] <= data_in;
        end
    end

    // Pointer updates; flush empties both FIFOs and overrides any pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr_a <= '0;
            r_rptr_a <= '0;
            r_wptr_b <= '0;
            r_rptr_b <= '0;
        end else if (flush) begin
            r_wptr_a <= '0;
            r_rptr_a <= '0;
            r_wptr_b <= '0;
            r_rptr_b <= '0;
        end else begin
            if (w_push_a) r_wptr_a <= r_wptr_a + PTR_ONE;
            if (w_pop_a)  r_rptr_a <= r_rptr_a + PTR_ONE;
            if (w_push_b) r_wptr_b <= r_wptr_b + PTR_ONE;
            if (w_pop_b)  r_rptr_b <= r_rptr_b + PTR_ONE;
        end
    end

    // Accept counters; untouched by flush, wrap naturally at 16 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (w_push_a) r_cnt_a <= r_cnt_a + 16'd1;
            if (w_push_b) r_cnt_b <= r_cnt_b + 16'd1;
        end
    end

endmodule

// File: tb/tb_demux2way16_stream.sv
// Self-checking bench for demux2way16_stream against a queue-based model.
module tb_demux2way16_stream;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 2;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] data_in;
    logic             sel;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [15:0]      cnt_a;
    logic [15:0]      cnt_b;

    demux2way16_stream #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .data_in  (data_in),
        .sel      (sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: one queue per port plus accept counters.
    logic [WIDTH-1:0] qa [$];
    logic [WIDTH-1:0] qb [$];
    int               m_cnt_a = 0;
    int               m_cnt_b = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("a_valid", 32'(a_valid), 32'(qa.size() != 0));
        check("b_valid", 32'(b_valid), 32'(qb.size() != 0));
        if (qa.size() != 0) check("a_data", 32'(a_data), 32'(qa[0]));
        if (qb.size() != 0) check("b_data", 32'(b_data), 32'(qb[0]));
        check("cnt_a", 32'(cnt_a), 32'(m_cnt_a));
        check("cnt_b", 32'(cnt_b), 32'(m_cnt_b));
    endtask

    // One clock cycle: drive, check readiness, clock, update model, check outputs.
    task automatic cycle(input logic v, input logic s, input logic [WIDTH-1:0] d,
                         input logic ar, input logic br, input logic fl);
        logic exp_rdy;
        logic pa;
        logic pb;
        in_valid = v;
        sel      = s;
        data_in  = d;
        a_ready  = ar;
        b_ready  = br;
        flush    = fl;
        #1;
        exp_rdy = !fl && (s ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        pa = !fl && ar && (qa.size() != 0);
        pb = !fl && br && (qb.size() != 0);
        if (fl) begin
            qa.delete();
            qb.delete();
        end else begin
            if (pa) void'(qa.pop_front());
            if (pb) void'(qb.pop_front());
        end
        if (v && exp_rdy) begin
            if (s) begin
                qb.push_back(d);
                m_cnt_b = (m_cnt_b + 1) % 65536;
            end else begin
                qa.push_back(d);
                m_cnt_a = (m_cnt_a + 1) % 65536;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        m_cnt_a = 0;
        m_cnt_b = 0;
    endtask

    initial begin
        reset_n  = 1'b0;
        data_in  = '0;
        sel      = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;

        // Reset state, before any clock edge.
        #1;
        check_outputs();
        check("in_ready_rst", 32'(in_ready), 32'd1);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        // Routing.
        cycle(1'b1, 1'b0, 16'h1111, 1'b1, 1'b1, 1'b0);
        check("route_a", 32'(a_data), 32'h1111);
        cycle(1'b1, 1'b1, 16'h2222, 1'b1, 1'b1, 1'b0);
        check("route_b", 32'(b_data), 32'h2222);
        check("route_cnt_a", 32'(cnt_a), 32'd1);
        check("route_cnt_b", 32'(cnt_b), 32'd1);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

        // Full / backpressure on a, b still accepts.
        cycle(1'b1, 1'b0, 16'hA001, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 16'hA002, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 16'hA003, 1'b0, 1'b1, 1'b0);
        check("full_a_rdy", 32'(in_ready), 32'd0);
        cycle(1'b1, 1'b1, 16'hB001, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("drain_a2", 32'(a_data), 32'hA002);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

        // Simultaneous push and pop on a.
        cycle(1'b1, 1'b0, 16'h0005, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 16'h0006, 1'b1, 1'b1, 1'b0);
        check("pp_data", 32'(a_data), 32'h0006);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

        // Flush with both FIFOs full.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 16'hC000 + 16'(i), 1'b0, 1'b0, 1'b0);
            cycle(1'b1, 1'b1, 16'hD000 + 16'(i), 1'b0, 1'b0, 1'b0);
        end
        cycle(1'b1, 1'b1, 16'hEEEE, 1'b1, 1'b1, 1'b1);
        check("flush_a_valid", 32'(a_valid), 32'd0);
        check("flush_b_valid", 32'(b_valid), 32'd0);

        // Randomized traffic, including sel/data churn with in_valid low.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom()),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset between edges with words buffered.
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h5678, 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("arst_a_valid", 32'(a_valid), 32'd0);
        check("arst_b_valid", 32'(b_valid), 32'd0);
        check("arst_cnt_a", 32'(cnt_a), 32'd0);
        check("arst_cnt_b", 32'(cnt_b), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        #2;
        reset_n = 1'b1;
        cycle(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0);

        // Counter wrap on port b.
        for (int i = 0; i < 65537; i++) begin
            cycle(1'b1, 1'b1, 16'(i * 7 + 3), 1'b0, 1'b1, 1'b0);
        end
        check("wrap_cnt_b", 32'(cnt_b), 32'h0001);
        check("wrap_cnt_a", 32'(cnt_a), 32'h0000);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux2way16_stream.md
DEMUX2WAY16_STREAM -- requirements
Module: demux2way16_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, entries per output FIFO (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port data_in  input  WIDTH  word offered by the source.
REQ-006 SHALL have port sel  input  1  destination select, qualified by in_valid (0 selects port a, 1 selects port b).
REQ-007 SHALL have port in_valid  input  1  source presents data_in/sel.
REQ-008 SHALL have port in_ready  output  1  block accepts the offered word this cycle.
REQ-009 SHALL have port flush  input  1  synchronous clear of both FIFOs.
REQ-010 SHALL have port a_data  output  WIDTH  head word of FIFO a.
REQ-011 SHALL have port a_valid  output  1  FIFO a non-empty.
REQ-012 SHALL have port a_ready  input  1  sink a consumes a_data.
REQ-013 SHALL have ports b_data, b_valid, b_ready, identical to REQ-010..012 for FIFO b.
REQ-014 SHALL have ports cnt_a, cnt_b  output  16  words accepted toward a / b since reset.

Function
REQ-015 Accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; the word SHALL be pushed into FIFO a if sel=0, or into FIFO b if sel=1.
REQ-016 in_ready SHALL be combinational: NOT flush AND NOT full(selected FIFO); it SHALL NOT depend on a_ready/b_ready (no pass-through when full).
REQ-017 The block SHALL never push into a full FIFO, and a word SHALL never be duplicated or dropped except by flush/reset.
REQ-018 x_valid SHALL equal NOT empty(x); x_data SHALL present the oldest word in FIFO x. x_data SHALL be don't-care when x_valid=0.
REQ-019 A pop of FIFO x SHALL occur on an edge with x_valid=1 and x_ready=1 and flush=0.
REQ-020 Latency SHALL be one cycle: a word accepted at edge N into an empty FIFO SHALL be visible on x_data with x_valid=1 immediately after edge N.
REQ-021 Per-port ordering SHALL be preserved; no ordering relation between ports is defined.
REQ-022 A simultaneous push and pop on the same non-full FIFO SHALL leave its occupancy unchanged and keep both words correctly ordered.
REQ-023 Push into one FIFO and pop from the other in the same cycle SHALL be independent.
REQ-024 Each FIFO SHALL use read/write pointers with one extra wrap bit; full = pointers equal except for the wrap bit, empty = pointers fully equal; pointers SHALL wrap modulo 2*DEPTH.
REQ-025 cnt_a/cnt_b SHALL increment by 1 on each accept to that port and wrap from 0xFFFF to 0x0000.
REQ-026 flush=1 SHALL empty both FIFOs at the next edge, force in_ready=0 and suppress pops that cycle; counters SHALL be unaffected.
REQ-027 sel and data_in changes while in_valid=0 SHALL have no effect on state.

Reset
REQ-028 While reset_n=0, independent of clk: both FIFOs empty, a_valid=0, b_valid=0, cnt_a=0, cnt_b=0, pointers=0.
REQ-029 in_ready SHALL be 1 during and after reset (flush=0), since both FIFOs are empty.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered words; no output valid SHALL be asserted until a new accept after reset_n=1.

Verification
REQ-031 Route: push 0x1111 (sel=0), 0x2222 (sel=1), a_ready=b_ready=1 -> a_data=0x1111 and b_data=0x2222 each valid one cycle after its accept; cnt_a=1, cnt_b=1.
REQ-032 Full/backpressure: a_ready=0, push 0xA001, 0xA002 to a -> in_ready=0 for sel=0 yet 1 for sel=1; push 0xB001 to b accepted; release a_ready -> a_data reads 0xA001 then 0xA002.
REQ-033 Simultaneous push/pop: FIFO a holds 1 word 0x0005, a_ready=1 with push 0x0006 (sel=0) -> occupancy stays 1, next a_data=0x0006.
REQ-034 Wrap: 65537 accepts to port b with b_ready=1 -> cnt_b=0x0001, cnt_a=0x0000, all words out in order.
REQ-035 Flush: both FIFOs full, flush=1 one cycle with a_ready=1 -> a_valid=b_valid=0 after the edge, no pop observed, in_ready=0 during flush, counters unchanged.
REQ-036 Async reset: with FIFOs holding 0x1234 (a) and 0x5678 (b), pulse reset_n=0 between clock edges -> a_valid, b_valid, cnt_a, cnt_b go to 0 immediately, without a clock edge.
